routing_unit_param: RTL and testbench

// - Generic per-input-port XY route-compute stage of the mesh NoC router; one instance per input (N/S/E/W/PE).
// - Pops packets from the input FWFT FIFO into a one-entry hold register and decodes the header.
// - Decrements the hop field it consumes, and raises one request toward the selected output arbiter.
// - Adds the following beyond the per-direction route blocks:
//   - input direction as a parameter;
//   - parametrised header field positions;
//   - back-to-back throughput;
//   - U-turn drop with error flag;
//   - stall watchdog.

---
 rtl/routing_unit_param.sv | 118 +++++++++++
 tb/tb_routing_unit_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/routing_unit_param.sv
// XY route-compute stage for one mesh router input port: one-entry hold register, hop decrement,
// U-turn drop and stall watchdog. Optional packet counter enabled by ROUTE_PKT_CNT_EN.
module routing_unit_param #(
  parameter int unsigned IN_DIR    = 3,
  parameter int unsigned PKT_W     = 64,
  parameter int unsigned DIRX_BIT  = 58,
  parameter int unsigned DIRY_BIT  = 57,
  parameter int unsigned HOPX_LSB  = 55,
  parameter int unsigned HOPY_LSB  = 53,
  parameter int unsigned HOP_W     = 2,
  parameter int unsigned STALL_MAX = 255,
  parameter int unsigned STALL_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             empty,
  input  logic [PKT_W-1:0] in_packet,
  output logic             read_en,
  input  logic [4:0]       full,
  output logic [PKT_W-1:0] out_packet,
  output logic [4:0]       out_req,
  output logic             err_uturn,
  output logic             stall_alarm
`ifdef ROUTE_PKT_CNT_EN
  ,
  output logic [15:0]      pkt_cnt
`endif
);

  localparam logic [2:0] DirN = 3'd0;
  localparam logic [2:0] DirS = 3'd1;
  localparam logic [2:0] DirE = 3'd2;
  localparam logic [2:0] DirW = 3'd3;
  localparam logic [2:0] DirPe = 3'd4;
  localparam logic [2:0] InDir = 3'(IN_DIR);
  localparam logic [STALL_W-1:0] StallMax = STALL_W'(STALL_MAX);

  logic               hold_valid_q, hold_valid_d;
  logic [PKT_W-1:0]   hold_q, hold_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               err_uturn_q, stall_alarm_q, stall_alarm_d;

  logic [HOP_W-1:0] hop_x, hop_y;
  logic [2:0]       dest;
  logic [PKT_W-1:0] route_pkt;
  logic             illegal, dest_full, xfer, drop, blocked;

  assign hop_x = hold_q[HOPX_LSB +: HOP_W];
  assign hop_y = hold_q[HOPY_LSB +: HOP_W];

  // XY order: exhaust X hops first, then Y, then deliver locally.
  always_comb begin
    route_pkt = hold_q;
    dest      = DirPe;
    if (hop_x != '0) begin
      dest = hold_q[DIRX_BIT] ? DirW : DirE;
      route_pkt[HOPX_LSB +: HOP_W] = hop_x - HOP_W'(1);
    end else if (hop_y != '0) begin
      dest = hold_q[DIRY_BIT] ? DirS : DirN;
      route_pkt[HOPY_LSB +: HOP_W] = hop_y - HOP_W'(1);
    end
  end

  assign illegal   = hold_valid_q && (dest == InDir) && (InDir != DirPe);
  assign dest_full = full[dest];
  assign xfer      = hold_valid_q && !illegal && !dest_full;
  assign drop      = illegal;
  assign blocked   = hold_valid_q && !illegal && dest_full;

  assign out_req    = xfer ? (5'b00001 << dest) : 5'b00000;
  assign out_packet = route_pkt;
  // Gate with reset so no pop escapes while the hold register is being cleared.
  assign read_en    = reset && !empty && (!hold_valid_q || xfer || drop);

  always_comb begin
    hold_d       = read_en ? in_packet : hold_q;
    hold_valid_d = read_en || (hold_valid_q && !(xfer || drop));
    stall_cnt_d  = '0;
    if (blocked) begin
      stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + STALL_W'(1);
    end
    stall_alarm_d = (stall_cnt_d >= StallMax);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid_q  <= 1'b0;
      hold_q        <= '0;
      stall_cnt_q   <= '0;
      err_uturn_q   <= 1'b0;
      stall_alarm_q <= 1'b0;
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_q        <= hold_d;
      stall_cnt_q   <= stall_cnt_d;
      err_uturn_q   <= drop;
      stall_alarm_q <= stall_alarm_d;
    end
  end

  assign err_uturn   = err_uturn_q;
  assign stall_alarm = stall_alarm_q;

`ifdef ROUTE_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt_q <= '0;
    end else if (xfer) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_routing_unit_param.sv
// Bench for routing_unit_param: vector table, directed corner sequences and a randomized run
// checked against a queue-based reference model of the route stage.
module tb_routing_unit_param;

  localparam int IN_DIR    = 3;
  localparam int STALL_MAX = 4;
  localparam int STALL_SAT = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        empty = 1'b1;
  logic [63:0] in_packet = '0;
  logic        read_en;
  logic [4:0]  full = '0;
  logic [63:0] out_packet;
  logic [4:0]  out_req;
  logic        err_uturn;
  logic        stall_alarm;
`ifdef ROUTE_PKT_CNT_EN
  logic [15:0] pkt_cnt;
`endif

  always #5 clk = ~clk;

  routing_unit_param #(
    .IN_DIR   (IN_DIR),
    .STALL_MAX(STALL_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .empty      (empty),
    .in_packet  (in_packet),
    .read_en    (read_en),
    .full       (full),
    .out_packet (out_packet),
    .out_req    (out_req),
    .err_uturn  (err_uturn),
    .stall_alarm(stall_alarm)
`ifdef ROUTE_PKT_CNT_EN
    ,
    .pkt_cnt    (pkt_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] fifo[$];

  // Reference model state
  bit          m_held;
  logic [63:0] m_pkt;
  int          m_stall;
  int          m_cnt;

  // Outputs sampled in the most recent tick
  logic [4:0]  s_req;
  logic        s_rd, s_err, s_alarm;
  logic [63:0] s_pkt;

  typedef struct {
    logic [63:0] pkt;
    logic [4:0]  exp_req;
    logic [63:0] exp_out;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input bit dx, input bit dy, input logic [1:0] hx,
                                     input logic [1:0] hy, input logic [52:0] pl);
    return {5'h15, dx, dy, hx, hy, pl};
  endfunction

  // Route by arithmetic on the whole word: a nonzero field can be decremented by subtraction.
  function automatic void route(input logic [63:0] p, output int dest, output logic [63:0] q);
    logic [63:0] hx, hy;
    hx = (p >> 55) & 64'd3;
    hy = (p >> 53) & 64'd3;
    q = p;
    if (hx != 0) begin
      dest = p[58] ? 3 : 2;
      q = p - (64'd1 << 55);
    end else if (hy != 0) begin
      dest = p[57] ? 1 : 0;
      q = p - (64'd1 << 53);
    end else begin
      dest = 4;
    end
  endfunction

  // Called at posedge+1; returns at the next posedge+1 with the model advanced.
  task automatic tick();
    int dest;
    logic [63:0] q;
    bit illegal, xfer, blocked, e_rd;
    logic [4:0] e_req;
    empty = (fifo.size() == 0);
    in_packet = empty ? 64'h0 : fifo[0];
    #3;
    route(m_pkt, dest, q);
    illegal = m_held && (dest == IN_DIR) && (IN_DIR != 4);
    e_req = (m_held && !illegal && !full[dest]) ? 5'(1 << dest) : 5'b0;
    xfer = (e_req != 0);
    e_rd = !empty && (!m_held || xfer || illegal);
    s_req = out_req; s_rd = read_en; s_err = err_uturn; s_alarm = stall_alarm; s_pkt = out_packet;
    chk("model out_req", s_req, e_req);
    chk("model read_en", s_rd, e_rd);
    if (m_held) chk("model out_packet", s_pkt, q);
`ifdef ROUTE_PKT_CNT_EN
    chk("model pkt_cnt", pkt_cnt, m_cnt);
`endif
    @(posedge clk);
    blocked = m_held && !illegal && full[dest];
    if (e_rd) begin
      m_pkt = fifo.pop_front();
      m_held = 1;
    end else if (xfer || illegal) begin
      m_held = 0;
    end
    m_stall = blocked ? ((m_stall < STALL_SAT) ? m_stall + 1 : STALL_SAT) : 0;
    if (xfer) m_cnt = (m_cnt + 1) % 65536;
    #1;
    chk("model err_uturn", err_uturn, illegal);
    chk("model stall_alarm", stall_alarm, m_stall >= STALL_MAX);
  endtask

  task automatic apply_reset();
    empty = (fifo.size() == 0);
    in_packet = empty ? 64'h0 : fifo[0];
    reset = 1'b0;
    #1;
    chk("rst out_req", out_req, 0);
    chk("rst read_en", read_en, 0);
    chk("rst out_packet", out_packet, 0);
    chk("rst err_uturn", err_uturn, 0);
    chk("rst stall_alarm", stall_alarm, 0);
`ifdef ROUTE_PKT_CNT_EN
    chk("rst pkt_cnt", pkt_cnt, 0);
`endif
    m_held = 0; m_pkt = '0; m_stall = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    vec_t tbl[5];
    tbl[0] = '{mk(0, 0, 2, 1, 53'h0_1234_5678_9abc), 5'b00100,
               mk(0, 0, 1, 1, 53'h0_1234_5678_9abc), 1'b0};
    tbl[1] = '{mk(0, 1, 0, 2, 53'h1f_0000_dead_beef), 5'b00010,
               mk(0, 1, 0, 1, 53'h1f_0000_dead_beef), 1'b0};
    tbl[2] = '{mk(1, 0, 0, 3, 53'h0_5555_aaaa_5555), 5'b00001,
               mk(1, 0, 0, 2, 53'h0_5555_aaaa_5555), 1'b0};
    tbl[3] = '{mk(1, 1, 0, 0, 53'h1_ffff_ffff_ffff), 5'b10000,
               mk(1, 1, 0, 0, 53'h1_ffff_ffff_ffff), 1'b0};
    tbl[4] = '{mk(1, 0, 1, 2, 53'h0_0000_0000_0042), 5'b00000,
               mk(1, 0, 0, 2, 53'h0_0000_0000_0042), 1'b1};

    @(posedge clk);
    #1;
    apply_reset();

    // Single packets through an idle stage, full=0
    foreach (tbl[i]) begin
      fifo.push_back(tbl[i].pkt);
      tick();
      chk("tbl pop", s_rd, 1'b1);
      tick();
      chk("tbl out_req", s_req, tbl[i].exp_req);
      chk("tbl out_packet", s_pkt, tbl[i].exp_out);
      tick();
      chk("tbl err_uturn", s_err, tbl[i].exp_err);
    end

    // U-turn drop followed immediately by the next FIFO word
    fifo.push_back(mk(1, 0, 1, 0, 53'h77));
    fifo.push_back(mk(0, 0, 0, 0, 53'h88));
    tick();
    tick();
    chk("uturn next pop", s_rd, 1'b1);
    chk("uturn no req", s_req, 5'b0);
    tick();
    chk("uturn err pulse", s_err, 1'b1);
    chk("uturn next sent", s_req, 5'b10000);
    tick();
    chk("uturn err single", s_err, 1'b0);

    // Blocked on south for 4 cycles
    fifo.push_back(mk(0, 1, 0, 2, 53'h99));
    fifo.push_back(mk(0, 0, 0, 0, 53'haa));
    full = 5'b00010;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("blk out_req", s_req, 5'b0);
      chk("blk read_en", s_rd, 1'b0);
    end
    full = 5'b0;
    tick();
    chk("blk release req", s_req, 5'b00010);
    chk("blk hop_y", s_pkt[54:53], 2'd1);
    chk("blk release pop", s_rd, 1'b1);
    tick();
    tick();

    // Back-to-back PE traffic
    apply_reset();
    for (int k = 0; k < 8; k++) fifo.push_back(mk(k[0], k[1], 0, 0, 53'($urandom)));
    tick();
    chk("b2b first pop", s_rd, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("b2b out_req", s_req, 5'b10000);
      chk("b2b read_en", s_rd, k < 8);
    end
`ifdef ROUTE_PKT_CNT_EN
    chk("b2b pkt_cnt", pkt_cnt, 16'd8);
`endif
    tick();

    // Stall watchdog with full[2] held
    fifo.push_back(mk(0, 0, 1, 0, 53'hbb));
    full = 5'b00100;
    tick();
    for (int t = 2; t <= 7; t++) begin
      tick();
      chk("stall alarm", s_alarm, t >= 6);
    end
    full = 5'b0;
    tick();
    chk("stall release req", s_req, 5'b00100);
    chk("stall alarm held", s_alarm, 1'b1);
    tick();
    chk("stall alarm clear", s_alarm, 1'b0);

    // Reset while holding a blocked packet
    fifo.push_back(mk(0, 0, 1, 0, 53'hcc));
    fifo.push_back(mk(0, 0, 0, 0, 53'hdd));
    full = 5'b00100;
    tick();
    tick();
    full = 5'b0;
    apply_reset();
    tick();
    chk("post-rst no resend", s_req, 5'b0);
    tick();
    chk("post-rst next pkt", s_req, 5'b10000);
    tick();
    chk("post-rst idle", s_req, 5'b0);

    // Randomized traffic with bursty backpressure
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(7) == 0) full = 5'($urandom);
      if (fifo.size() < 4 && $urandom_range(1) == 1) fifo.push_back({$urandom, $urandom});
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
